// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - state, opcode and mux-select encodings for multicycle_controller
package multicycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECUTER, EXECUTEI, ALUWB, JAL, BRANCH, FAULT
  } state_t;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_REG   = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  typedef struct packed {
    logic       adr_src;
    logic       mem_write;
    logic       reg_write;
    logic       jump;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Pure Moore part of the datapath controls; handshake-gated strobes are added in the top.
  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.result_src = RES_ALURESULT; c.alu_src_a = SRCA_PC; c.alu_src_b = SRCB_FOUR; c.alu_op = ALU_ADD; end
      DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
      MEMADR:   begin c.alu_src_a = SRCA_REG; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
      MEMREAD:  begin c.adr_src = 1'b1; c.result_src = RES_ALUOUT; end
      MEMWB:    begin c.result_src = RES_READDATA; c.reg_write = 1'b1; end
      MEMWRITE: begin c.adr_src = 1'b1; c.mem_write = 1'b1; end
      EXECUTER: begin c.alu_src_a = SRCA_REG; c.alu_src_b = SRCB_REG; c.alu_op = ALU_FUNCT; end
      EXECUTEI: begin c.alu_src_a = SRCA_REG; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_FUNCT; end
      ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
      JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALUOUT; c.jump = 1'b1; end
      BRANCH:   begin c.alu_src_a = SRCA_REG; c.alu_src_b = SRCB_REG; c.alu_op = ALU_SUB; c.result_src = RES_ALUOUT; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic logic [1:0] imm_sel(logic [6:0] op);
    case (op)
      OP_SW:     return IMM_S;
      OP_BRANCH: return IMM_B;
      OP_JAL:    return IMM_J;
      default:   return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_mem_wait_timer.sv
// rtl/multicycle_controller_mem_wait_timer.sv - consecutive !mem_ready counter with timeout compare
module mem_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT_CYCLES - 1);

  logic [7:0] count;

  // Any exit from a wait state passes through mem_ready or timeout, so those clear it too.
  always_ff @(posedge clk) begin
    if (rst || !waiting || mem_ready || timeout)
      count <= '0;
    else
      count <= count + 8'd1;
  end

  assign timeout = waiting && !mem_ready && (count == LIMIT);

endmodule

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - multicycle RV32I control FSM; PERF_CNT_EN adds cycle/instret counters
module multicycle_controller #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int PERF_CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  PCWrite,
  output logic                  AdrSrc,
  output logic                  MemWrite,
  output logic                  IRWrite,
  output logic                  RegWrite,
  output logic [1:0]            ResultSrc,
  output logic [1:0]            ALUSrcA,
  output logic [1:0]            ALUSrcB,
  output logic [1:0]            ALUOp,
  output logic [1:0]            ImmSrc,
  output logic                  trap,
  output logic [1:0]            trap_cause,
  output logic [PERF_CNT_W-1:0] cycle_count,
  output logic [PERF_CNT_W-1:0] instret_count
);
  import multicycle_ctrl_pkg::*;

  state_t     state, state_n;
  ctrl_t      ctrl;
  logic [1:0] cause_n;
  logic       waiting, timeout;
  logic       unused_funct3;

  assign unused_funct3 = ^funct3[2:1];
  assign waiting = state inside {FETCH, MEMREAD, MEMWRITE};

  mem_wait_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_comb begin
    state_n = state;
    cause_n = CAUSE_NONE;
    case (state)
      FETCH, MEMREAD, MEMWRITE: begin
        if (mem_ready) begin
          if (state == FETCH)        state_n = DECODE;
          else if (state == MEMREAD) state_n = MEMWB;
          else                       state_n = FETCH;
        end else if (timeout) begin
          state_n = FAULT;
          cause_n = CAUSE_TIMEOUT;
        end
      end
      DECODE: begin
        case (op)
          OP_LW, OP_SW: state_n = MEMADR;
          OP_RTYPE:     state_n = EXECUTER;
          OP_ITYPE:     state_n = EXECUTEI;
          OP_JAL:       state_n = JAL;
          OP_BRANCH:    state_n = BRANCH;
          default: begin
            state_n = FAULT;
            cause_n = CAUSE_ILLEGAL;
          end
        endcase
      end
      MEMADR: begin
        if (op == OP_SW) state_n = MEMWRITE;
        else             state_n = MEMREAD;
      end
      EXECUTER, EXECUTEI, JAL: state_n = ALUWB;
      MEMWB, ALUWB, BRANCH:    state_n = FETCH;
      default:                 state_n = state;
    endcase
  end

  // Datapath selects are registered from the next state so they are glitch-free Moore outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FETCH;
      ctrl       <= state_ctrl(FETCH);
      trap       <= 1'b0;
      trap_cause <= CAUSE_NONE;
    end else begin
      state <= state_n;
      ctrl  <= state_ctrl(state_n);
      if (state != FAULT && state_n == FAULT) begin
        trap       <= 1'b1;
        trap_cause <= cause_n;
      end
    end
  end

  assign PCWrite   = !rst && ((state == FETCH && mem_ready) ||
                              (state == BRANCH && (zero ^ funct3[0])) || ctrl.jump);
  assign IRWrite   = !rst && state == FETCH && mem_ready;
  assign MemWrite  = !rst && ctrl.mem_write;
  assign RegWrite  = !rst && ctrl.reg_write;
  assign AdrSrc    = ctrl.adr_src;
  assign ResultSrc = ctrl.result_src;
  assign ALUSrcA   = ctrl.alu_src_a;
  assign ALUSrcB   = ctrl.alu_src_b;
  assign ALUOp     = ctrl.alu_op;
  assign ImmSrc    = imm_sel(op);

`ifdef PERF_CNT_EN
  logic [PERF_CNT_W-1:0] cycle_q, instret_q;
  logic                  retire;

  assign retire = state_n == FETCH && (state inside {MEMWB, MEMWRITE, ALUWB, BRANCH});

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state != FAULT) cycle_q <= cycle_q + PERF_CNT_W'(1);
      if (retire)         instret_q <= instret_q + PERF_CNT_W'(1);
    end
  end

  assign cycle_count   = cycle_q;
  assign instret_count = instret_q;
`else
  assign cycle_count   = '0;
  assign instret_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

  localparam int TO = 16;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp}
  localparam logic [12:0] V_FETCH_WAIT = 13'b0_0_0_0_0_10_00_10_00;
  localparam logic [12:0] V_FETCH_GO   = 13'b1_0_0_1_0_10_00_10_00;
  localparam logic [12:0] V_DECODE     = 13'b0_0_0_0_0_00_01_01_00;
  localparam logic [12:0] V_MEMADR     = 13'b0_0_0_0_0_00_10_01_00;
  localparam logic [12:0] V_MEMREAD    = 13'b0_1_0_0_0_00_00_00_00;
  localparam logic [12:0] V_MEMWB      = 13'b0_0_0_0_1_01_00_00_00;
  localparam logic [12:0] V_MEMWRITE   = 13'b0_1_1_0_0_00_00_00_00;
  localparam logic [12:0] V_EXECR      = 13'b0_0_0_0_0_00_10_00_10;
  localparam logic [12:0] V_EXECI      = 13'b0_0_0_0_0_00_10_01_10;
  localparam logic [12:0] V_ALUWB      = 13'b0_0_0_0_1_00_00_00_00;
  localparam logic [12:0] V_JAL        = 13'b1_0_0_0_0_00_01_10_00;
  localparam logic [12:0] V_BR_T       = 13'b1_0_0_0_0_00_10_00_01;
  localparam logic [12:0] V_BR_N       = 13'b0_0_0_0_0_00_10_00_01;
  localparam logic [12:0] V_ZERO       = 13'b0;

  logic        clk = 1'b0;
  logic        rst, zero, mem_ready;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, trap;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap_cause;
  logic [31:0] cycle_count, instret_count;

  always #5 clk = ~clk;

  multicycle_controller #(.TIMEOUT_CYCLES(TO), .PERF_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .op(op), .funct3(funct3), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ALUOp(ALUOp), .ImmSrc(ImmSrc), .trap(trap), .trap_cause(trap_cause),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        zero;
    logic        rdy;
    logic        cnt;
    logic [12:0] exp;
  } cyc_t;

  cyc_t q[$];
  cyc_t tbl [18];
  int   n_cmp = 0, n_bad = 0, exp_cyc = 0, exp_ret = 0;

  function automatic logic [1:0] imm_model(logic [6:0] o);
    if (o == OP_SW)  return 2'b01;
    if (o == OP_BR)  return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic apply(input cyc_t c, input string nm);
    op = c.op; funct3 = c.f3; zero = c.zero; mem_ready = c.rdy;
    @(negedge clk);
    check(nm, 32'({PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc}),
          32'({c.exp, imm_model(c.op)}));
    @(posedge clk); #1;
    if (c.cnt) exp_cyc++;
  endtask

  task automatic run_queue(input string tag);
    cyc_t c;
    int   k;
    k = 0;
    while (q.size() > 0) begin
      c = q.pop_front();
      apply(c, $sformatf("%s[%0d]", tag, k));
      k++;
    end
  endtask

  task automatic push(input logic [6:0] o, input logic [2:0] f, input int zs, input int rs,
                      input logic [12:0] v, input logic cnt);
    cyc_t c;
    c.op = o; c.f3 = f; c.exp = v; c.cnt = cnt;
    c.zero = (zs < 0) ? 1'($urandom_range(0, 1)) : 1'(zs);
    c.rdy  = (rs < 0) ? 1'($urandom_range(0, 1)) : 1'(rs);
    q.push_back(c);
  endtask

  // One whole instruction as seen cycle by cycle; stalls are counted in !mem_ready cycles.
  task automatic push_instr(input logic [6:0] o, input logic [2:0] f, input logic z,
                            input int fst, input int mst);
    for (int i = 0; i < fst; i++) push(o, f, -1, 0, V_FETCH_WAIT, 1'b1);
    push(o, f, -1, 1, V_FETCH_GO, 1'b1);
    push(o, f, -1, -1, V_DECODE, 1'b1);
    case (o)
      OP_LW: begin
        push(o, f, -1, -1, V_MEMADR, 1'b1);
        for (int i = 0; i < mst; i++) push(o, f, -1, 0, V_MEMREAD, 1'b1);
        push(o, f, -1, 1, V_MEMREAD, 1'b1);
        push(o, f, -1, -1, V_MEMWB, 1'b1);
      end
      OP_SW: begin
        push(o, f, -1, -1, V_MEMADR, 1'b1);
        for (int i = 0; i < mst; i++) push(o, f, -1, 0, V_MEMWRITE, 1'b1);
        push(o, f, -1, 1, V_MEMWRITE, 1'b1);
      end
      OP_R:   begin push(o, f, -1, -1, V_EXECR, 1'b1); push(o, f, -1, -1, V_ALUWB, 1'b1); end
      OP_I:   begin push(o, f, -1, -1, V_EXECI, 1'b1); push(o, f, -1, -1, V_ALUWB, 1'b1); end
      OP_JAL: begin push(o, f, -1, -1, V_JAL, 1'b1);   push(o, f, -1, -1, V_ALUWB, 1'b1); end
      default: push(o, f, int'(z), -1, (z ^ f[0]) ? V_BR_T : V_BR_N, 1'b1);
    endcase
    exp_ret++;
  endtask

  task automatic check_perf(input string tag);
    int ec, er;
    ec = exp_cyc; er = exp_ret;
`ifndef PERF_CNT_EN
    ec = 0; er = 0;
`endif
    check({tag, "_cycle_count"}, cycle_count, 32'(ec));
    check({tag, "_instret_count"}, instret_count, 32'(er));
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; mem_ready = 1'b1;
    @(negedge clk);
    check({tag, "_strobes_in_rst"}, 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_strobes_rst_fetch"}, 32'({PCWrite, MemWrite, IRWrite, RegWrite}), 32'd0);
    check({tag, "_trap_rst"}, 32'({trap, trap_cause}), 32'd0);
    check({tag, "_perf_rst"}, cycle_count | instret_count, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete(); exp_cyc = 0; exp_ret = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [6];
    logic [6:0] o;
    int fst;

    ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BR};
    tbl = '{
      '{OP_R,   3'b000, 1'b0, 1'b1, 1'b1, V_FETCH_GO},
      '{OP_R,   3'b000, 1'b0, 1'b1, 1'b1, V_DECODE},
      '{OP_R,   3'b000, 1'b0, 1'b1, 1'b1, V_EXECR},
      '{OP_R,   3'b000, 1'b0, 1'b1, 1'b1, V_ALUWB},
      '{OP_BR,  3'b000, 1'b1, 1'b1, 1'b1, V_FETCH_GO},
      '{OP_BR,  3'b000, 1'b1, 1'b1, 1'b1, V_DECODE},
      '{OP_BR,  3'b000, 1'b1, 1'b1, 1'b1, V_BR_T},
      '{OP_BR,  3'b001, 1'b1, 1'b1, 1'b1, V_FETCH_GO},
      '{OP_BR,  3'b001, 1'b1, 1'b1, 1'b1, V_DECODE},
      '{OP_BR,  3'b001, 1'b1, 1'b1, 1'b1, V_BR_N},
      '{OP_I,   3'b000, 1'b0, 1'b1, 1'b1, V_FETCH_GO},
      '{OP_I,   3'b000, 1'b0, 1'b1, 1'b1, V_DECODE},
      '{OP_I,   3'b000, 1'b0, 1'b1, 1'b1, V_EXECI},
      '{OP_I,   3'b000, 1'b0, 1'b1, 1'b1, V_ALUWB},
      '{OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, V_FETCH_GO},
      '{OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, V_DECODE},
      '{OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, V_JAL},
      '{OP_JAL, 3'b000, 1'b0, 1'b1, 1'b1, V_ALUWB}
    };

    op = OP_R; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b1; rst = 1'b1;

    do_reset("tbl");
    for (int i = 0; i < 18; i++) apply(tbl[i], $sformatf("tbl[%0d]", i));
    exp_ret = 5;
    check_perf("tbl");

    // lw with three stalled reads, then the rest of the mixed program
    do_reset("prog");
    push_instr(OP_LW, 3'b010, 1'b0, 0, 3);
    push_instr(OP_SW, 3'b010, 1'b0, 1, 2);
    push_instr(OP_R, 3'b000, 1'b0, 0, 0);
    push_instr(OP_JAL, 3'b000, 1'b0, 0, 0);
    push_instr(OP_BR, 3'b000, 1'($urandom_range(0, 1)), 0, 0);
    run_queue("prog");
    check_perf("prog");

    do_reset("ill");
    push(OP_BAD, 3'b000, -1, 1, V_FETCH_GO, 1'b1);
    push(OP_BAD, 3'b000, -1, -1, V_DECODE, 1'b1);
    run_queue("ill_pre");
    check("ill_trap_entry", 32'({trap, trap_cause}), 32'b101);
    for (int i = 0; i < 20; i++) push(OP_BAD, 3'($urandom_range(0, 7)), -1, -1, V_ZERO, 1'b0);
    run_queue("ill_hold");
    check("ill_trap_hold", 32'({trap, trap_cause}), 32'b101);
    check_perf("ill");
    do_reset("ill_clr");
    push_instr(OP_R, 3'b000, 1'b0, 0, 0);
    run_queue("ill_after");

    do_reset("to");
    push(OP_SW, 3'b010, -1, 1, V_FETCH_GO, 1'b1);
    push(OP_SW, 3'b010, -1, -1, V_DECODE, 1'b1);
    push(OP_SW, 3'b010, -1, -1, V_MEMADR, 1'b1);
    for (int i = 0; i < TO; i++) push(OP_SW, 3'b010, -1, 0, V_MEMWRITE, 1'b1);
    for (int i = 0; i < 3; i++) push(OP_SW, 3'b010, -1, -1, V_ZERO, 1'b0);
    run_queue("to");
    check("to_trap", 32'({trap, trap_cause}), 32'b110);
    check_perf("to");

    do_reset("to_edge");
    push_instr(OP_SW, 3'b010, 1'b0, TO - 1, TO - 1);
    push_instr(OP_R, 3'b000, 1'b0, 0, 0);
    run_queue("to_edge");
    check("to_edge_trap", 32'({trap, trap_cause}), 32'b000);
    check_perf("to_edge");

    // reset asserted while a store is stalled must suppress MemWrite at once
    do_reset("mid");
    push(OP_SW, 3'b010, -1, 1, V_FETCH_GO, 1'b1);
    push(OP_SW, 3'b010, -1, -1, V_DECODE, 1'b1);
    push(OP_SW, 3'b010, -1, -1, V_MEMADR, 1'b1);
    push(OP_SW, 3'b010, -1, 0, V_MEMWRITE, 1'b1);
    push(OP_SW, 3'b010, -1, 0, V_MEMWRITE, 1'b1);
    run_queue("mid");
    do_reset("mid_abort");
    push_instr(OP_I, 3'b000, 1'b0, 0, 0);
    run_queue("mid_after");
    check_perf("mid_after");

    do_reset("rnd");
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 5)];
      fst = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TO - 1)) : 0;
      push_instr(o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), fst,
                 int'($urandom_range(0, TO - 1)));
    end
    run_queue("rnd");
    check_perf("rnd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
